// File: rtl/code_serializer.sv
`default_nettype none
//==============================================================================
// Module   : code_serializer
// Purpose  : Serial code transmitter feeding the single-bit x input of the
//            sequential code-lock detector. A parallel code word is accepted
//            through a valid/ready handshake, shifted out MSB-first one bit
//            per clock, and followed by a programmable number of idle cycles.
//
// Parameters:
//   CODE_W     - code word width in bits (1..16)
//   GAP_CYC    - idle cycles inserted after each frame (0..255)
//   IDLE_LEVEL - level driven on x_out when no data bit is being sent
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   code_in    in   [CODE_W] word to transmit, sampled only on a transfer edge
//   code_valid in   code_in holds a valid word
//   code_ready out  block accepts a word this cycle (high only in IDLE)
//   x_out      out  registered serial bit stream
//   busy       out  high while a frame or its gap is in progress
//   done       out  one-cycle pulse after the last bit of a frame was driven
//   frame_cnt  out  [8] count of completed frames, wraps 255 -> 0
//
// Optional feature (macro CODE_SER_PARITY_EN):
//   When defined, an even-parity bit (XOR of all data bits) is sent as one
//   extra SHIFT cycle after the last data bit; done moves one cycle later.
//
// Revision : 1.0 - initial release
//==============================================================================

module code_serializer #(
    parameter int   CODE_W     = 4,
    parameter int   GAP_CYC    = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              x_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    localparam int             BCW       = $clog2(CODE_W + 2);
    localparam logic [BCW-1:0] C_CNT_ONE = BCW'(1);
    localparam logic [BCW-1:0] C_CNT_LD  = BCW'(CODE_W);
    localparam logic [7:0]     C_GAP_LD  = 8'(GAP_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [CODE_W-1:0]   shift_q,     shift_d;
    logic [BCW-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [7:0]          gap_cnt_q,   gap_cnt_d;
    logic                x_q,         x_d;
    logic                done_q,      done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
`ifdef CODE_SER_PARITY_EN
    logic                parity_q,    parity_d;
`endif
    logic                w_frame_end;

    // Ready is a pure decode of the state so it never depends on code_valid.
    assign code_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign x_out      = x_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        x_d         = x_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
`ifdef CODE_SER_PARITY_EN
        parity_d    = parity_q;
`endif
        w_frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_d = IDLE_LEVEL;
                if (code_valid) begin
                    // The MSB goes straight onto the line, so the shift
                    // register keeps only the bits still to be sent,
                    // left-aligned.
                    x_d       = code_in[CODE_W-1];
                    shift_d   = code_in << 1;
                    bit_cnt_d = C_CNT_LD;
                    state_d   = ST_SHIFT;
`ifdef CODE_SER_PARITY_EN
                    parity_d  = ^code_in;
`endif
                end
            end

            ST_SHIFT: begin
                // bit_cnt_q counts data bits not yet finished on the line,
                // including the one currently driven.
`ifdef CODE_SER_PARITY_EN
                if (bit_cnt_q == '0) begin
                    w_frame_end = 1'b1;
                end else if (bit_cnt_q == C_CNT_ONE) begin
                    x_d       = parity_q;
                    bit_cnt_d = '0;
                end else begin
                    x_d       = shift_q[CODE_W-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - C_CNT_ONE;
                end
`else
                if (bit_cnt_q <= C_CNT_ONE) begin
                    w_frame_end = 1'b1;
                end else begin
                    x_d       = shift_q[CODE_W-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - C_CNT_ONE;
                end
`endif
            end

            ST_GAP: begin
                x_d = IDLE_LEVEL;
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                // Unreachable encoding: return to a clean IDLE but keep the
                // frame count, which is still meaningful.
                state_d   = ST_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                x_d       = IDLE_LEVEL;
`ifdef CODE_SER_PARITY_EN
                parity_d  = 1'b0;
`endif
            end
        endcase

        if (w_frame_end) begin
            x_d         = IDLE_LEVEL;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
            bit_cnt_d   = '0;
            shift_d     = '0;
            if (GAP_CYC > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = C_GAP_LD;
            end else begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            x_q         <= IDLE_LEVEL;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef CODE_SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            x_q         <= x_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CODE_SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_serializer.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_code_serializer
// Purpose  : Self-checking bench for code_serializer. A table of code words
//            with hand-written MSB-first streams and parity bits drives the
//            default instance (CODE_W=4, GAP_CYC=2); hand-written sequences
//            cover back-to-back frames, GAP_CYC=0, mid-frame reset and the
//            frame counter wrap. Honours CODE_SER_PARITY_EN.
// Revision : 1.0 - initial release
//==============================================================================

module tb_code_serializer;

`ifdef CODE_SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int P0 = 4 + PB + 1;   // frame period of the GAP_CYC=0 instance

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code_in, code_in0;
    logic       code_valid, code_valid0;
    logic       code_ready, code_ready0;
    logic       x_out, x_out0;
    logic       busy, busy0;
    logic       done, done0;
    logic [7:0] frame_cnt, frame_cnt0;

    always #5 clk = ~clk;

    code_serializer #(.CODE_W(4), .GAP_CYC(2), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .x_out(x_out), .busy(busy), .done(done),
        .frame_cnt(frame_cnt)
    );

    code_serializer #(.CODE_W(4), .GAP_CYC(0), .IDLE_LEVEL(1'b0)) dut_g0 (
        .clk(clk), .reset(rst), .code_in(code_in0), .code_valid(code_valid0),
        .code_ready(code_ready0), .x_out(x_out0), .busy(busy0), .done(done0),
        .frame_cnt(frame_cnt0)
    );

    typedef struct {
        logic [3:0] code;   // word presented on code_in
        logic [3:0] bits;   // expected stream, first bit sent at [3]
        logic       par;    // expected even-parity bit
    } vec_t;

    vec_t       tbl [6];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_fc = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered at the negedge of cycle k+1; leaves at the negedge of the first
    // IDLE cycle after the gap.
    task automatic check_body(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            chk("data_bit", x_out, v.bits[3-i]);
            chk("busy_shift", busy, 1);
            chk("done_shift", done, 0);
            chk("ready_shift", code_ready, 0);
            @(negedge clk);
        end
`ifdef CODE_SER_PARITY_EN
        chk("parity_bit", x_out, v.par);
        chk("done_parity", done, 0);
        @(negedge clk);
`endif
        exp_fc = exp_fc + 8'd1;
        chk("done_pulse", done, 1);
        chk("x_gap1", x_out, 0);
        chk("busy_gap1", busy, 1);
        chk("frame_cnt", frame_cnt, exp_fc);
        @(negedge clk);
        chk("done_gap2", done, 0);
        chk("x_gap2", x_out, 0);
        chk("busy_gap2", busy, 1);
        @(negedge clk);
        chk("ready_back", code_ready, 1);
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
    endtask

    initial begin
        int n;

        tbl[0] = '{4'b0101, 4'b0101, 1'b0};
        tbl[1] = '{4'b0100, 4'b0100, 1'b1};
        tbl[2] = '{4'b0111, 4'b0111, 1'b1};
        tbl[3] = '{4'b1111, 4'b1111, 1'b0};
        tbl[4] = '{4'b1000, 4'b1000, 1'b1};
        tbl[5] = '{4'b0110, 4'b0110, 1'b0};

        rst = 1'b1; code_in = '0; code_valid = 1'b0; code_in0 = '0; code_valid0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", x_out, 0);
        chk("rst_ready", code_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fc", frame_cnt, 0);
        chk("rst_ready0", code_ready0, 1);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single frames with a one-cycle valid pulse.
        for (int i = 0; i < 6; i++) begin
            chk("ready_pre", code_ready, 1);
            code_in = tbl[i].code; code_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            code_valid = 1'b0; code_in = 4'b1010;   // must be ignored
            check_body(tbl[i]);
        end

        // Back-to-back: valid held high across two frames.
        code_in = 4'b0100; code_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        code_in = 4'b0101;
        check_body(tbl[1]);
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        check_body(tbl[0]);
        repeat (10) @(negedge clk);
        chk("b2b_no_extra_busy", busy, 0);
        chk("b2b_frame_cnt", frame_cnt, exp_fc);

        // GAP_CYC=0 instance: frames repeat every P0 cycles.
        code_in0 = 4'b1111; code_valid0 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("g0_done", done0, ((c - 1) % P0) == (P0 - 1));
            chk("g0_x", x_out0, ((c - 1) % P0) < 4);
        end
        code_valid0 = 1'b0;
        chk("g0_frame_cnt", frame_cnt0, 20 / P0);

        // Reset during cycle k+2 of a 0101 frame.
        code_in = 4'b0101; code_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        chk("mid_bit0", x_out, 0);
        @(negedge clk);
        chk("mid_bit1", x_out, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_x", x_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fc", frame_cnt, 0);
        chk("mid_rst_ready", code_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_fc = 8'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("mid_no_done", done, 0);
        end

        // 256 back-to-back frames: counter wrap.
        code_in = 4'b0000; code_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 4000 && n < 256; c++) begin
            @(negedge clk);
            if (done) begin
                n++;
                if (n == 255) chk("wrap_255", frame_cnt, 255);
                if (n == 256) begin
                    chk("wrap_0", frame_cnt, 0);
                    code_valid = 1'b0;
                end
            end
        end
        chk("wrap_frames_seen", n, 256);
        code_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/code_serializer.md
Name: code_serializer

Overview:
- Serial code transmitter that drives the single-bit `x` input of the sequential code-lock detector.
- Accepts a parallel code word through a valid/ready handshake, shifts it out MSB-first one bit per clock, then holds the line idle for a programmable gap.
- Lets test fixtures and upstream control logic present unlock codes (e.g. 0101, 0100) to the detector without hand-toggling `x`.

Parameters:
- CODE_W, 4, code word width in bits (legal 1..16).
- GAP_CYC, 2, idle cycles inserted after each frame (legal 0..255).
- IDLE_LEVEL, 0, value driven on x_out when no data bit is being sent (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- code_in  input  CODE_W  code word to transmit; sampled only on handshake.
- code_valid  input  1  code_in holds a valid word.
- code_ready  output  1  block can accept a word this cycle.
- x_out  output  1  serial bit stream, registered; connects to the detector's x.
- busy  output  1  high while in SHIFT or GAP.
- done  output  1  one-cycle pulse after the last bit (or parity bit) of a frame has been driven.
- frame_cnt  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset values (asynchronous, take effect immediately): state=IDLE, x_out=IDLE_LEVEL, code_ready=1, busy=0, done=0, frame_cnt=0, shift register=0, counters=0.
- States:
  - IDLE: code_ready=1, busy=0, x_out=IDLE_LEVEL.
  - SHIFT: code_ready=0, busy=1.
  - GAP: code_ready=0, busy=1, x_out=IDLE_LEVEL.
- Handshake:
  - Transfer occurs on the rising edge where code_valid=1 and code_ready=1 (edge k).
  - code_ready is combinational from state (high only in IDLE); it never depends on code_valid.
  - code_in is ignored outside a transfer edge.
  - code_valid held high while busy has no effect and is not queued.
- IDLE -> SHIFT at edge k:
  - Capture code_in into the shift register and load the bit counter with CODE_W.
  - x_out = code_in[CODE_W-1] from edge k (visible in cycle k+1).
- SHIFT:
  - Each subsequent edge shifts left and drives the next lower bit.
  - Bit i (MSB = bit 0 of the frame) is on x_out during cycle k+1+i, for i = 0..CODE_W-1.
- End of SHIFT (edge after the last data bit):
  - If GAP_CYC>0: go to GAP and drive x_out=IDLE_LEVEL.
  - If GAP_CYC=0: go directly to IDLE.
  - In both cases done=1 for exactly that one following cycle (cycle k+1+CODE_W) and frame_cnt increments by 1 on the same edge.
- GAP: stays exactly GAP_CYC cycles, then returns to IDLE.
- Back-to-back frames:
  - The earliest next transfer edge is the first edge with code_ready=1.
  - Minimum frame period = CODE_W + GAP_CYC + 1 cycles (the IDLE acceptance cycle included).
- Counter widths: bit counter sized clog2(CODE_W+2); gap counter 8 bits; no counter overflows within legal parameter ranges.
- frame_cnt: 8-bit unsigned, wraps modulo 256 silently.
- Reset asserted mid-SHIFT or mid-GAP: frame aborted immediately, x_out returns to IDLE_LEVEL, no done pulse, frame_cnt cleared to 0.
- Unreachable state encodings recover to IDLE with reset values (frame_cnt preserved).

Optional Feature:
- Macro: CODE_SER_PARITY_EN.
- Defined:
  - After the last data bit, one extra SHIFT cycle drives the even-parity bit (XOR of all CODE_W captured bits).
  - done and frame_cnt increment move one cycle later, to cycle k+2+CODE_W.
  - Minimum frame period becomes CODE_W + GAP_CYC + 2.
- Undefined: no parity bit; timing exactly as in Behaviour.

Test Plan:
- Reset, then code_in=4'b0101 with code_valid=1 for one cycle (edge k) -> x_out = 0,1,0,1 in cycles k+1..k+4; done=1 in cycle k+5 only; x_out=0 in cycles k+5,k+6; code_ready=1 again in cycle k+7; frame_cnt=1.
- code_in=4'b0100 then 4'b0101 with code_valid held high continuously -> exactly two frames, streams 0100 and 0101, separated by 2 idle bits plus the acceptance cycle; frame_cnt=2; no extra frame.
- GAP_CYC=0, CODE_W=4, code_valid held high with code_in=4'b1111 -> frames repeat every 5 cycles; done pulses every 5 cycles.
- Reset asserted during cycle k+2 of a 0101 frame -> x_out=0 immediately, busy=0, no done pulse, frame_cnt=0, code_ready=1.
- 256 back-to-back frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
- With CODE_SER_PARITY_EN, send 4'b0111 -> x_out = 0,1,1,1,1 (parity 1) in cycles k+1..k+5; done in cycle k+6.
